fadd_scheduler: RTL and testbench

- Shares one combinational single-precision float adder between two requesters (e.g. FADD/FSUB issue and an FP accumulate path) with round-robin arbitration.
- Only one operation is in flight at a time.
- Latches the operands and applies subtraction by flipping the sign of b.
- Holds the operands stable for LATENCY cycles so the adder's long combinational path settles, then registers the result behind a valid/ready response port.
- Sits in the floating-point execute stage, between the issue logic and the adder instance.

---
 rtl/fadd_scheduler.sv | 97 +++++++++
 tb/tb_fadd_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_scheduler.sv
// fadd_scheduler: round-robin sharing of one combinational float adder between two requesters
module fadd_scheduler #(
  parameter int LATENCY = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t state, state_n;
  logic ptr;
  logic [3:0] cnt;
  logic any_req, grant1;
  logic [31:0] sel_a, sel_b;
  logic sel_sub;
  logic [TAG_W-1:0] sel_tag;
  // ptr=1 means requester 1 wins a tie
  assign any_req = req0_valid | req1_valid;
  assign grant1 = req1_valid & (~req0_valid | ptr);
  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_b = grant1 ? req1_b : req0_b;
  assign sel_sub = grant1 ? req1_sub : req0_sub;
  assign sel_tag = grant1 ? req1_tag : req0_tag;
  // state register; busy is registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
    end
  end
  // next-state: accept in IDLE, count down in WAIT, drain in RESP
  always_comb begin
    state_n = (state == IDLE && any_req) ? WAIT :
              (state == WAIT && cnt == 4'd1) ? RESP :
              (state == RESP && resp_ready) ? IDLE : state;
  end
  // ready outputs only ever pulse for the granted requester in IDLE
  always_comb begin
    req0_ready = !reset && state == IDLE && any_req && !grant1;
    req1_ready = !reset && state == IDLE && grant1;
  end
  // datapath: latch operands on accept, capture the sum on the last WAIT edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
      cnt <= 4'd0;
      add_a <= '0;
      add_b <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_id <= 1'b0;
      resp_tag <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        add_a <= sel_a;
        add_b <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
        resp_id <= grant1;
        resp_tag <= sel_tag;
        cnt <= LAT;
        if (req0_valid && req1_valid) ptr <= ~grant1;
      end
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        resp_data <= add_out;
        resp_valid <= 1'b1;
      end
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fadd_scheduler.sv
// tb_fadd_scheduler: directed checks of arbitration, latency, backpressure and reset
module tb_fadd_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req0_sub = 1'b0, req1_valid = 1'b0, req1_sub = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_tag = '0, req1_tag = '0;
  logic req0_ready, req1_ready, resp_valid, resp_id, busy;
  logic resp_ready = 1'b1;
  logic [31:0] add_a, add_b, add_out, resp_data;
  logic [3:0] resp_tag;
  logic l5_req0_valid = 1'b0, l5_resp_ready = 1'b1;
  logic l5_req0_ready, l5_req1_ready, l5_resp_valid, l5_resp_id, l5_busy;
  logic [31:0] l5_add_a, l5_add_b, l5_resp_data;
  logic [31:0] l5_add_out = 32'h12345678;
  logic [3:0] l5_resp_tag;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
    if (a == 32'h40700000 && b == 32'hBFC00000) return 32'h40100000;
    return a ^ b;
  endfunction
  assign add_out = fadd_model(add_a, add_b);
  fadd_scheduler #(.LATENCY(2), .TAG_W(4)) u0 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_tag(req1_tag),
    .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_tag(resp_tag), .busy(busy)
  );
  fadd_scheduler #(.LATENCY(5), .TAG_W(4)) u5 (
    .clk(clk), .reset(reset),
    .req0_valid(l5_req0_valid), .req0_ready(l5_req0_ready), .req0_a(32'h3FC00000),
    .req0_b(32'h40100000), .req0_sub(1'b0), .req0_tag(4'd3),
    .req1_valid(1'b0), .req1_ready(l5_req1_ready), .req1_a(32'h0), .req1_b(32'h0),
    .req1_sub(1'b0), .req1_tag(4'd0),
    .add_a(l5_add_a), .add_b(l5_add_b), .add_out(l5_add_out),
    .resp_valid(l5_resp_valid), .resp_ready(l5_resp_ready), .resp_data(l5_resp_data),
    .resp_id(l5_resp_id), .resp_tag(l5_resp_tag), .busy(l5_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset state, with a request present that must not be granted
    req0_valid = 1'b1;
    tick();
    tick();
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_tag", 32'(resp_tag), 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();
    // single add on requester 0
    req0_a = 32'h3FC00000; req0_b = 32'h40100000; req0_sub = 1'b0; req0_tag = 4'd3; req0_valid = 1'b1;
    #1;
    chk("add_ready0", 32'(req0_ready), 1);
    chk("add_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_ready0_low", 32'(req0_ready), 0);
    chk("add_busy1", 32'(busy), 1);
    chk("add_opa", add_a, 32'h3FC00000);
    chk("add_opb", add_b, 32'h40100000);
    tick();
    chk("add_no_early_valid", 32'(resp_valid), 0);
    chk("add_busy2", 32'(busy), 1);
    tick();
    chk("add_valid", 32'(resp_valid), 1);
    chk("add_data", resp_data, 32'h40700000);
    chk("add_id", 32'(resp_id), 0);
    chk("add_tag", 32'(resp_tag), 3);
    chk("add_busy3", 32'(busy), 1);
    tick();
    chk("add_done_valid", 32'(resp_valid), 0);
    chk("add_done_busy", 32'(busy), 0);
    // subtract on requester 1, then backpressure
    req1_a = 32'h40700000; req1_b = 32'h3FC00000; req1_sub = 1'b1; req1_tag = 4'd5; req1_valid = 1'b1;
    resp_ready = 1'b0;
    #1;
    chk("sub_ready1", 32'(req1_ready), 1);
    chk("sub_ready0", 32'(req0_ready), 0);
    tick();
    req1_valid = 1'b0;
    chk("sub_opb", add_b, 32'hBFC00000);
    tick();
    chk("sub_opb_held", add_b, 32'hBFC00000);
    tick();
    chk("sub_valid", 32'(resp_valid), 1);
    chk("sub_data", resp_data, 32'h40100000);
    chk("sub_id", 32'(resp_id), 1);
    chk("sub_tag", 32'(resp_tag), 5);
    req0_a = 32'h3FC00000; req0_b = 32'h40100000; req0_sub = 1'b0; req0_tag = 4'd7; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready0", 32'(req0_ready), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
      tick();
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_data", resp_data, 32'h40100000);
      chk("bp_id", 32'(resp_id), 1);
      chk("bp_tag", 32'(resp_tag), 5);
      chk("bp_add_a", add_a, 32'h40700000);
      chk("bp_add_b", add_b, 32'hBFC00000);
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(resp_valid), 0);
    chk("bp_release_busy", 32'(busy), 0);
    chk("bp_release_ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    chk("post_bp_valid", 32'(resp_valid), 1);
    chk("post_bp_tag", 32'(resp_tag), 7);
    chk("post_bp_data", resp_data, 32'h40700000);
    tick();
    // contention from reset release: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_a = 32'h11110000; req0_b = 32'h00002222; req0_sub = 1'b0; req0_tag = 4'd1; req0_valid = 1'b1;
    req1_a = 32'h33330000; req1_b = 32'h00004444; req1_sub = 1'b1; req1_tag = 4'd2; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      chk("ct_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      tick();
      if (i % 2 == 0) req0_tag = req0_tag + 4'd2;
      else req1_tag = req1_tag + 4'd2;
      tick();
      tick();
      chk("ct_valid", 32'(resp_valid), 1);
      chk("ct_id", 32'(resp_id), 32'(i % 2));
      chk("ct_tag", 32'(resp_tag), 32'(i + 1));
      chk("ct_data", resp_data, (i % 2 == 0) ? 32'h11112222 : 32'hB3334444);
      tick();
    end
    // contested grant to req0 points at req1, then reset one cycle into WAIT
    req0_a = 32'h3FC00000; req0_b = 32'h40100000; req0_tag = 4'd9;
    #1;
    chk("rw_ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rw_valid", 32'(resp_valid), 0);
    chk("rw_data", resp_data, 0);
    chk("rw_add_a", add_a, 0);
    chk("rw_add_b", add_b, 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_id", 32'(resp_id), 0);
    chk("rw_tag", 32'(resp_tag), 0);
    chk("rw_ready1", 32'(req1_ready), 0);
    reset = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("rw_next_ready0", 32'(req0_ready), 1);
    chk("rw_next_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rw_next_valid", 32'(resp_valid), 0);
    tick();
    chk("rw_next_valid2", 32'(resp_valid), 0);
    tick();
    chk("rw_next_tag", 32'(resp_tag), 9);
    chk("rw_next_data", resp_data, 32'h40700000);
    tick();
    // LATENCY=5 instance: capture exactly on the fifth edge
    l5_req0_valid = 1'b1;
    #1;
    chk("l5_ready", 32'(l5_req0_ready), 1);
    chk("l5_ready1", 32'(l5_req1_ready), 0);
    tick();
    l5_req0_valid = 1'b0;
    chk("l5_add_a", l5_add_a, 32'h3FC00000);
    chk("l5_add_b", l5_add_b, 32'h40100000);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("l5_no_early_valid", 32'(l5_resp_valid), 0);
      chk("l5_busy", 32'(l5_busy), 1);
    end
    l5_add_out = 32'h40700000;
    tick();
    chk("l5_valid", 32'(l5_resp_valid), 1);
    chk("l5_data", l5_resp_data, 32'h40700000);
    chk("l5_id", 32'(l5_resp_id), 0);
    chk("l5_tag", 32'(l5_resp_tag), 3);
    tick();
    chk("l5_done", 32'(l5_resp_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
